bt_update_queue: RTL and testbench
==================================

// Module: bt_update_queue
// PURPOSE
//  Producer side of the BTUpdate interface into the branch target buffer.
//  - Accepts BTUpdate records from branch resolution and buffers them in a small FIFO.
//  - Replays them to the BTB one per cycle, at most, from a registered output.
//  - Enforces the BTB's write rules: no writes during its post-reset init sweep; one idle cycle after every multiple=1 update, so the BTB can drain its deferred "multiple" write.
// PARAMETERS
//  DEPTH        4                  FIFO entries (power of two, >=2)
//  INIT_CYCLES  `BTB_ENTRIES + 1   cycles after reset before the first output is allowed
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      asynchronous reset, active-low (0 = reset)
//  IN_flush      in   1      drop all queued updates (fence.i / BTB invalidate)
//  IN_btUpdate   in   BTUpdate  resolved update; .valid qualifies; always accepted or dropped, never stalled
//  OUT_btUpdate  out  BTUpdate  registered update to the BTB; .valid = write this cycle
//  OUT_busy      out  1      init counter running or FIFO non-empty
//  OUT_dropCnt   out  16     count of updates lost to overflow; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (rst=0, async)
//   - OUT_btUpdate.valid=0, other fields 'x; OUT_busy=1; OUT_dropCnt=0.
//   - FIFO emptied; state=INIT; init counter=0.
//   - Reset asserted mid-operation discards the FIFO and any pending GAP immediately.
//  States
//   - INIT: count to INIT_CYCLES-1, then go to RUN. Pushes are accepted in INIT; no pops.
//   - RUN: if FIFO non-empty, pop the head and register it onto OUT_btUpdate with valid=1. If the popped entry has .multiple=1 (and .clean=0), go to GAP.
//   - GAP: exactly one cycle with output valid=0, then go to RUN.
//  Latency
//   - Push at edge N appears on OUT_btUpdate no earlier than the cycle after edge N+1.
//   - There is no combinational bypass from IN to OUT.
//  Output
//   - OUT_btUpdate.valid is high for exactly one cycle per popped entry; otherwise valid=0.
//   - Payload is passed through unmodified (src, dst, btype, compressed, clean, multiple, multipleOffs, fetchStartOffs).
//  FIFO boundaries
//   - Full, push with no pop: drop the incoming update; OUT_dropCnt+1 (saturating).
//   - Full, push with a pop in the same cycle: accept the push; no drop.
//   - Empty, push: no same-cycle pop; the entry is popped next cycle if state=RUN.
//   - Pointers are log2(DEPTH)+1 bits wide; full/empty use the wrap bit.
//  IN_flush
//   - Empties the FIFO, including any same-cycle push.
//   - Does not change state; a GAP in progress still completes.
//   - An update already registered on OUT is not revoked.
//   - No drop is counted.
//  Ordering: strict FIFO. A clean and a write to the same index keep their order.
// CONFIGURATION
//  BTB_UPD_COALESCE_EN defined
//   - An incoming update is discarded without counting if it is bit-identical (all fields except valid) to the youngest queued entry.
//   - This also applies when the FIFO is full.
//   - A one-entry "last" shadow register holds the youngest entry; it is cleared on flush and on reset.
//  BTB_UPD_COALESCE_EN undefined
//   - Every valid input is pushed or counted as a drop. No shadow register exists.
// STRUCTURE
//  - Shared package gains typedef enum logic[1:0] {BUQ_INIT, BUQ_RUN, BUQ_GAP} BTUpdQState_t.
//  - BTUpdate, BranchType and FetchOff_t stay in the existing package.
//  - One sub-module: bt_update_fifo (DEPTH x BTUpdate payload, push/pop/flush, full/empty).
//  - The top level holds the FSM, init counter, output register, drop counter and optional coalesce shadow.
// TESTING
//  1. Reset release, DEPTH=4, INIT_CYCLES=9; push A at cycle 2 -> OUT valid=0 through cycle 9; A on OUT at cycle 10; OUT_busy falls after that.
//  2. RUN, push A(multiple=1) then B and C back-to-back -> OUT: A, idle, B, C; never two valid cycles with the first having multiple=1.
//  3. Stall pops by holding INIT, push 6 updates -> 4 queued, OUT_dropCnt=2. Then push into a full FIFO on a pop cycle in RUN -> accepted, dropCnt unchanged.
//  4. Queue 3 entries, assert IN_flush with a simultaneous push -> FIFO empty, no further valid outputs, dropCnt unchanged.
//  5. Assert rst low mid-GAP with 2 entries queued -> OUT valid=0 immediately and FIFO empty; after release, INIT restarts for the full INIT_CYCLES.
//  6. BTB_UPD_COALESCE_EN: push X, X, Y, X -> three entries issued (X, Y, X), dropCnt=0. Without the macro -> four issued.

Source files
------------

// File: rtl/bt_update_queue_pkg.sv
//------------------------------------------------------------------------------
// Module  : bt_update_queue_pkg
// Brief   : Shared BTUpdate record, branch type and update-queue state types.
//           BTB_ENTRIES may be overridden on the command line; the queue's
//           init period is derived from it.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef BTB_ENTRIES
`define BTB_ENTRIES 8
`endif

package bt_update_queue_pkg;

    // Number of BTB entries swept by the BTB's post-reset init.
    localparam int BTB_NUM_ENTRIES = `BTB_ENTRIES;

    typedef logic [2:0] FetchOff_t;

    typedef enum logic [1:0] {
        BT_BRANCH = 2'd0,
        BT_JUMP   = 2'd1,
        BT_CALL   = 2'd2,
        BT_RETURN = 2'd3
    } BranchType;

    // valid is kept as the LSB so the payload can be compared as one slice.
    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        BranchType   btype;
        logic        compressed;
        logic        clean;
        logic        multiple;
        FetchOff_t   multipleOffs;
        FetchOff_t   fetchStartOffs;
        logic        valid;
    } BTUpdate;

    typedef enum logic [1:0] {
        BUQ_INIT = 2'd0,
        BUQ_RUN  = 2'd1,
        BUQ_GAP  = 2'd2
    } BTUpdQState_t;

endpackage

`default_nettype wire

// File: rtl/bt_update_fifo.sv
//------------------------------------------------------------------------------
// Module  : bt_update_fifo
// Brief   : DEPTH-entry FIFO of BTUpdate records with push/pop/flush.
//           Pointers carry an extra wrap bit to tell full from empty.
//           rst is asynchronous and active-low.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bt_update_fifo
    import bt_update_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  logic    i_pop,
    input  logic    i_flush,
    input  BTUpdate i_data,
    output BTUpdate o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    BTUpdate       mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          w_wr_en;
    logic          w_rd_en;

    assign o_empty = (wptr_q == rptr_q);
    assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign o_head  = mem_q[rptr_q[AW-1:0]];

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_wr_en = i_push && !i_flush && (!o_full || i_pop);
    assign w_rd_en = i_pop && !i_flush && !o_empty;

    // Pointer advance; flush discards everything, including a same-cycle push.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (i_flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (w_wr_en) wptr_d = wptr_q + PW'(1);
            if (w_rd_en) rptr_d = rptr_q + PW'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (w_wr_en) mem_q[wptr_q[AW-1:0]] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/bt_update_queue.sv
//------------------------------------------------------------------------------
// Module  : bt_update_queue
// Brief   : Buffers resolved BTUpdate records and replays them to the BTB
//           from a registered output, holding off during the BTB init sweep
//           and leaving one idle cycle after every multiple=1 update.
//           Optional feature macro: BTB_UPD_COALESCE_EN (discard an update
//           identical to the youngest queued one).
//           rst is asynchronous and active-low.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bt_update_queue
    import bt_update_queue_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int INIT_CYCLES = BTB_NUM_ENTRIES + 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        IN_flush,
    input  BTUpdate     IN_btUpdate,
    output BTUpdate     OUT_btUpdate,
    output logic        OUT_busy,
    output logic [15:0] OUT_dropCnt
);

    localparam int          CNT_W    = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

    BTUpdQState_t state_q, state_d;
    logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
    BTUpdate      out_q, out_d;
    logic [15:0]  drop_cnt_q, drop_cnt_d;

    BTUpdate w_fifo_head;
    logic    w_fifo_full;
    logic    w_fifo_empty;
    logic    w_pop;
    logic    w_push;
    logic    w_drop;
    logic    w_in_valid;
    logic    w_coal_hit;

    bt_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (IN_flush),
        .i_data  (IN_btUpdate),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef BTB_UPD_COALESCE_EN
    BTUpdate last_q, last_d;
    logic    last_vld_q, last_vld_d;

    // Duplicate of the youngest still-queued entry carries no new information.
    always_comb begin
        w_coal_hit = last_vld_q && !w_fifo_empty &&
                     (IN_btUpdate[$bits(BTUpdate)-1:1] == last_q[$bits(BTUpdate)-1:1]);
        last_d     = last_q;
        last_vld_d = last_vld_q;
        if (IN_flush) begin
            last_vld_d = 1'b0;
        end else if (w_push) begin
            last_d     = IN_btUpdate;
            last_vld_d = 1'b1;
        end
    end

    // Shadow of the youngest queued entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q     <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign w_coal_hit = 1'b0;
`endif

    // Input acceptance: push when there is room (or room appears this cycle), else count a drop.
    always_comb begin
        w_in_valid = IN_btUpdate.valid && !w_coal_hit;
        w_push     = w_in_valid && !IN_flush && (!w_fifo_full || w_pop);
        w_drop     = w_in_valid && !IN_flush && w_fifo_full && !w_pop;
        drop_cnt_d = drop_cnt_q;
        if (w_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Next state, init counting and pop/output selection.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        out_d      = '0;
        w_pop      = 1'b0;
        case (state_q)
            BUQ_INIT: begin
                if (init_cnt_q == CNT_LAST) state_d = BUQ_RUN;
                else                        init_cnt_d = init_cnt_q + CNT_W'(1);
            end
            BUQ_RUN: begin
                // A flush suppresses the pop so nothing from the dropped queue escapes.
                if (!w_fifo_empty && !IN_flush) begin
                    w_pop       = 1'b1;
                    out_d       = w_fifo_head;
                    out_d.valid = 1'b1;
                    if (w_fifo_head.multiple && !w_fifo_head.clean) state_d = BUQ_GAP;
                end
            end
            BUQ_GAP: begin
                state_d = BUQ_RUN;
            end
            default: begin
                state_d = BUQ_INIT;
            end
        endcase
    end

    // State, counters and registered output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BUQ_INIT;
            init_cnt_q <= '0;
            out_q      <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            out_q      <= out_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign OUT_btUpdate = out_q;
    assign OUT_busy     = (state_q == BUQ_INIT) || !w_fifo_empty;
    assign OUT_dropCnt  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_bt_update_queue.sv
//------------------------------------------------------------------------------
// Module  : tb_bt_update_queue
// Brief   : Self-checking bench for bt_update_queue (DEPTH=4, INIT_CYCLES=9).
//           Expected outputs are queued as stimulus is driven and matched
//           against every valid output cycle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bt_update_queue;
    import bt_update_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    BTUpdate     in_upd;
    BTUpdate     out_upd;
    logic        busy;
    logic [15:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    BTUpdate sb[$];

    bt_update_queue #(
        .DEPTH       (4),
        .INIT_CYCLES (9)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_flush     (flush),
        .IN_btUpdate  (in_upd),
        .OUT_btUpdate (out_upd),
        .OUT_busy     (busy),
        .OUT_dropCnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    // Output monitor: every valid cycle must match the scoreboard head and respect the gap rule.
    initial begin
        BTUpdate exp;
        logic    prev_gap_req;
        prev_gap_req = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                prev_gap_req = 1'b0;
            end else if (out_upd.valid === 1'b1) begin
                checks++;
                if (prev_gap_req) begin
                    errors++;
                    $display("FAIL gap_rule: got valid output %h right after a multiple=1 update, required an idle cycle", out_upd);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h, required no output", out_upd);
                end else begin
                    exp = sb.pop_front();
                    if (out_upd !== exp) begin
                        errors++;
                        $display("FAIL scoreboard: got %h, required %h", out_upd, exp);
                    end
                end
                prev_gap_req = out_upd.multiple && !out_upd.clean;
            end else begin
                prev_gap_req = 1'b0;
            end
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic BTUpdate mk(input logic mult);
        BTUpdate r;
        r.src            = $urandom;
        r.dst            = $urandom;
        r.btype          = BranchType'(2'($urandom_range(0, 3)));
        r.compressed     = 1'($urandom_range(0, 1));
        r.clean          = 1'b0;
        r.multiple       = mult;
        r.multipleOffs   = 3'($urandom_range(0, 7));
        r.fetchStartOffs = 3'($urandom_range(0, 7));
        r.valid          = 1'b1;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for two edges, releases it 1 time unit after an edge ("cycle 0").
    task automatic apply_reset();
        rst    = 1'b0;
        flush  = 1'b0;
        in_upd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        flush  = 1'b0;
        in_upd = '0;
        #2;
        checks++;
        if (out_upd.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b, required 0", out_upd.valid);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy: got %b, required 1", busy);
        end
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_dropcnt: got %0d, required 0", drop_cnt);
        end
    endtask

    task automatic test_init_latency();
        BTUpdate a;
        logic    ev;
        a = mk(1'b0);
        apply_reset();
        for (int c = 1; c <= 11; c++) begin
            if (c == 2) begin
                in_upd = a;
                sb.push_back(a);
            end
            step();
            in_upd = '0;
            ev = (c == 10);
            checks++;
            if (out_upd.valid !== ev) begin
                errors++;
                $display("FAIL init_latency_valid: cycle %0d got valid=%b, required %b", c, out_upd.valid, ev);
            end
            if (c == 9) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL init_busy_high: got %b, required 1", busy);
                end
            end
            if (c == 10) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL init_busy_low: got %b, required 0", busy);
                end
            end
        end
    endtask

    task automatic test_gap();
        BTUpdate u[3];
        logic    ev;
        logic    pat [1:6];
        pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        u[0] = mk(1'b1);
        u[1] = mk(1'b0);
        u[2] = mk(1'b0);
        for (int c = 1; c <= 6; c++) begin
            if (c <= 3) begin
                in_upd = u[c-1];
                sb.push_back(u[c-1]);
            end
            step();
            in_upd = '0;
            ev = pat[c];
            checks++;
            if (out_upd.valid !== ev) begin
                errors++;
                $display("FAIL gap_pattern: cycle %0d got valid=%b, required %b", c, out_upd.valid, ev);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_gap: got %0d pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_overflow();
        BTUpdate r;
        apply_reset();
        for (int c = 1; c <= 6; c++) begin
            r = mk(1'b0);
            in_upd = r;
            if (c <= 4) sb.push_back(r);
            step();
            in_upd = '0;
        end
        checks++;
        if (drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL overflow_dropcnt: got %0d, required 2", drop_cnt);
        end
        repeat (3) step();
        // Edge 10 is the first pop: a push into the full FIFO must be accepted.
        r = mk(1'b0);
        in_upd = r;
        sb.push_back(r);
        step();
        in_upd = '0;
        checks++;
        if (out_upd.valid !== 1'b1) begin
            errors++;
            $display("FAIL overflow_first_pop: got valid=%b, required 1", out_upd.valid);
        end
        checks++;
        if (drop_cnt !== 16'd2) begin
            errors++;
            $display("FAIL overflow_push_on_pop: got dropcnt %0d, required 2", drop_cnt);
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_overflow: got %0d pending, required 0", sb.size());
            sb.delete();
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL overflow_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int c = 1; c <= 14; c++) begin
            if (c <= 4) in_upd = mk(1'b0);
            if (c == 4) flush = 1'b1;
            step();
            in_upd = '0;
            flush  = 1'b0;
            checks++;
            if (out_upd.valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_no_output: cycle %0d got valid=1, required 0", c);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: got busy=%b, required 0", busy);
        end
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL flush_dropcnt: got %0d, required 0", drop_cnt);
        end
    endtask

    task automatic test_reset_mid_gap();
        BTUpdate m;
        BTUpdate d;
        logic    ev;
        m = mk(1'b1);
        apply_reset();
        for (int c = 1; c <= 10; c++) begin
            if (c == 1) begin
                in_upd = m;
                sb.push_back(m);
            end
            if (c == 2 || c == 3) in_upd = mk(1'b0);
            step();
            in_upd = '0;
        end
        checks++;
        if (out_upd.valid !== 1'b1 || out_upd.multiple !== 1'b1) begin
            errors++;
            $display("FAIL midgap_setup: got valid=%b multiple=%b, required 1 1", out_upd.valid, out_upd.multiple);
        end
        // Assert reset asynchronously in the middle of the GAP cycle.
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (out_upd.valid !== 1'b0) begin
            errors++;
            $display("FAIL midgap_reset_valid: got %b, required 0", out_upd.valid);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midgap_reset_busy: got %b, required 1", busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        d = mk(1'b0);
        for (int c = 1; c <= 14; c++) begin
            if (c == 2) begin
                in_upd = d;
                sb.push_back(d);
            end
            step();
            in_upd = '0;
            ev = (c == 10);
            checks++;
            if (out_upd.valid !== ev) begin
                errors++;
                $display("FAIL midgap_reinit: cycle %0d got valid=%b, required %b", c, out_upd.valid, ev);
            end
        end
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL midgap_empty: got busy=%b pending=%0d, required 0 0", busy, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_coalesce();
        BTUpdate x;
        BTUpdate y;
        BTUpdate seq[4];
        x = mk(1'b0);
        y = x;
        y.src = x.src ^ 32'h1;
        seq = '{x, x, y, x};
        sb.push_back(x);
`ifndef BTB_UPD_COALESCE_EN
        sb.push_back(x);
`endif
        sb.push_back(y);
        sb.push_back(x);
        apply_reset();
        for (int c = 1; c <= 4; c++) begin
            in_upd = seq[c-1];
            step();
            in_upd = '0;
        end
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL coalesce_dropcnt: got %0d, required 0", drop_cnt);
        end
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_coalesce: got %0d pending, required 0", sb.size());
            sb.delete();
        end
        repeat (5) step();
    endtask

    initial begin
        test_reset();
        test_init_latency();
        test_gap();
        test_overflow();
        test_flush();
        test_reset_mid_gap();
        test_coalesce();
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
